// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: buffers one input vector, then for each group of N_PU
// neurons streams weights, accumulates signed MACs, requantises and emits the results.
module mlp_layer_engine #(
  parameter int N_IN  = 62,
  parameter int N_OUT = 30,
  parameter int N_PU  = 8,
  parameter int DW    = 8,
  parameter int SHIFT = 7,
  localparam int G    = (N_OUT + N_PU - 1) / N_PU,
  localparam int AW   = 2*DW + $clog2(N_IN) + 1,
  localparam int WAW  = (G*N_IN > 1) ? $clog2(G*N_IN) : 1,
  localparam int OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 relu_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 w_rd,
  output logic [WAW-1:0]       w_addr,
  input  logic [N_PU*DW-1:0]   w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [OW-1:0]        out_index,
  output logic                 out_last,
  output logic [OW-1:0]        argmax_class,
  output logic                 done
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int LW = (N_PU > 1) ? $clog2(N_PU) : 1;
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (DW-1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_EMIT, S_DONE
  } state_t;

  state_t                 state_q;
  logic                   relu_q;
  logic [WAW-1:0]         grpBase_q;
  logic [OW-1:0]          idxBase_q;
  logic [IW-1:0]          i_q;
  logic [IW-1:0]          macIdx_q;
  logic                   macValid_q;
  logic [LW-1:0]          lane_q;
  logic signed [DW-1:0]   buf_q [N_IN];
  logic signed [AW-1:0]   acc_q [N_PU];
  logic signed [AW-1:0]   acc_d [N_PU];
  logic signed [DW-1:0]   bestVal_q;
  logic [OW-1:0]          bestIdx_q;
  logic [OW-1:0]          bestIdx_d;
  logic                   haveBest_q;
  logic                   takeNew;
  logic                   grpEnd;
  logic [LW-1:0]          nextLane;
  logic signed [AW-1:0]   selAcc;

  logic                   in_ready_q;
  logic                   w_rd_q;
  logic [WAW-1:0]         w_addr_q;
  logic                   out_valid_q;
  logic [DW-1:0]          out_data_q;
  logic [OW-1:0]          out_index_q;
  logic                   out_last_q;
  logic [OW-1:0]          argmax_class_q;
  logic                   done_q;

  assign in_ready     = in_ready_q;
  assign w_rd         = w_rd_q;
  assign w_addr       = w_addr_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_index    = out_index_q;
  assign out_last     = out_last_q;
  assign argmax_class = argmax_class_q;
  assign done         = done_q;

  // Weight data arrives one cycle after the read, so the MAC uses the delayed index.
  for (genvar p = 0; p < N_PU; p++) begin : g_mac
    logic signed [DW-1:0]   wLane;
    logic signed [2*DW-1:0] prod;
    assign wLane    = w_data[p*DW +: DW];
    assign prod     = buf_q[macIdx_q] * wLane;
    assign acc_d[p] = macValid_q ? acc_q[p] + {{(AW-2*DW){prod[2*DW-1]}}, prod} : acc_q[p];
  end

  always_comb begin
    nextLane = lane_q + LW'(1);
    selAcc   = acc_q[0];
    for (int p = 0; p < N_PU; p++) begin
      if (LW'(p) == nextLane) selAcc = acc_q[p];
    end
  end

  assign takeNew   = !haveBest_q || ($signed(out_data_q) > bestVal_q);
  assign bestIdx_d = takeNew ? out_index_q : bestIdx_q;
  assign grpEnd    = out_last_q || (lane_q == LW'(N_PU-1));

  function automatic logic [DW-1:0] requant(input logic signed [AW-1:0] a, input logic relu);
    logic signed [AW-1:0] v;
    v = a >>> SHIFT;
    if (relu && v[AW-1]) v = '0;
    if (v > MAXV) v = MAXV;
    else if (v < MINV) v = MINV;
    return v[DW-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      relu_q         <= 1'b0;
      grpBase_q      <= '0;
      idxBase_q      <= '0;
      i_q            <= '0;
      macIdx_q       <= '0;
      macValid_q     <= 1'b0;
      lane_q         <= '0;
      bestVal_q      <= '0;
      bestIdx_q      <= '0;
      haveBest_q     <= 1'b0;
      in_ready_q     <= 1'b0;
      w_rd_q         <= 1'b0;
      w_addr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_index_q    <= '0;
      out_last_q     <= 1'b0;
      argmax_class_q <= '0;
      done_q         <= 1'b0;
      for (int i = 0; i < N_IN; i++) buf_q[i] <= '0;
      for (int p = 0; p < N_PU; p++) acc_q[p] <= '0;
    end else begin
      macValid_q <= w_rd_q;
      macIdx_q   <= i_q;
      done_q     <= 1'b0;
      for (int p = 0; p < N_PU; p++) acc_q[p] <= acc_d[p];
      case (state_q)
        S_IDLE: begin
          if (start) begin
            relu_q     <= relu_en;
            grpBase_q  <= '0;
            idxBase_q  <= '0;
            i_q        <= '0;
            haveBest_q <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready_q) begin
            buf_q[i_q] <= in_data;
            if (i_q == IW'(N_IN-1)) begin
              in_ready_q <= 1'b0;
              i_q        <= '0;
              w_rd_q     <= 1'b1;
              w_addr_q   <= grpBase_q;
              for (int p = 0; p < N_PU; p++) acc_q[p] <= '0;
              state_q    <= S_COMPUTE;
            end else begin
              i_q <= i_q + IW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (i_q == IW'(N_IN-1)) begin
            w_rd_q  <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            i_q      <= i_q + IW'(1);
            w_addr_q <= w_addr_q + WAW'(1);
          end
        end
        S_DRAIN: begin
          // acc_d already holds the final MAC of this group.
          lane_q      <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= requant(acc_d[0], relu_q);
          out_index_q <= idxBase_q;
          out_last_q  <= (idxBase_q == OW'(N_OUT-1));
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            haveBest_q <= 1'b1;
            if (takeNew) begin
              bestVal_q <= out_data_q;
              bestIdx_q <= out_index_q;
            end
            if (grpEnd) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (out_last_q) begin
                argmax_class_q <= bestIdx_d;
                done_q         <= 1'b1;
                state_q        <= S_DONE;
              end else begin
                grpBase_q <= grpBase_q + WAW'(N_IN);
                idxBase_q <= out_index_q + OW'(1);
                i_q       <= '0;
                w_rd_q    <= 1'b1;
                w_addr_q  <= grpBase_q + WAW'(N_IN);
                for (int p = 0; p < N_PU; p++) acc_q[p] <= '0;
                state_q   <= S_COMPUTE;
              end
            end else begin
              lane_q      <= nextLane;
              out_data_q  <= requant(selAcc, relu_q);
              out_index_q <= out_index_q + OW'(1);
              out_last_q  <= (out_index_q + OW'(1) == OW'(N_OUT-1));
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Self-checking bench for mlp_layer_engine: a plain-arithmetic layer model feeds
// expected address/output queues that a per-cycle monitor checks against the DUT.
module tb_mlp_layer_engine;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int N_PU  = 2;
  localparam int DW    = 8;
  localparam int SHIFT = 0;
  localparam int G     = 2;
  localparam int WAW   = 3;
  localparam int OW    = 2;
  localparam int WW    = N_PU*DW;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           relu_en;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           w_rd;
  logic [WAW-1:0] w_addr;
  logic [WW-1:0]  w_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [OW-1:0]  out_index;
  logic           out_last;
  logic [OW-1:0]  argmax_class;
  logic           done;

  always #5 clk = ~clk;

  mlp_layer_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_PU(N_PU), .DW(DW), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .argmax_class(argmax_class), .done(done)
  );

  int inVec [N_IN];
  int wgt [G*N_PU][N_IN];
  logic [WW-1:0] wmem [G*N_IN];
  int expData [$];
  int expIdx [$];
  int expAddr [$];
  int expArgmax;
  int tests = 0;
  int fails = 0;
  int rxData [N_OUT];
  int rxCount, doneCount, stallCount;
  bit stallArm;

  // Weight memory: one-cycle read latency, garbage whenever no read was issued.
  always @(posedge clk) begin
    if (w_rd) w_data <= wmem[w_addr];
    else      w_data <= WW'($urandom);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input int actual);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0d, expected an event that never came", name, actual);
  endtask

  task automatic buildModel(input logic relu);
    int best, sum, v;
    int maxV, minV;
    maxV = (1 << (DW-1)) - 1;
    minV = -(1 << (DW-1));
    expData.delete(); expIdx.delete(); expAddr.delete();
    best = 0;
    for (int n = 0; n < N_OUT; n++) begin
      sum = 0;
      for (int i = 0; i < N_IN; i++) sum += inVec[i] * wgt[n][i];
      v = sum >>> SHIFT;
      if (relu && v < 0) v = 0;
      if (v > maxV) v = maxV;
      if (v < minV) v = minV;
      expData.push_back(v);
      expIdx.push_back(n);
      if (n == 0 || v > expData[best]) best = n;
    end
    expArgmax = best;
    for (int a = 0; a < G*N_IN; a++) expAddr.push_back(a);
    for (int g = 0; g < G; g++)
      for (int i = 0; i < N_IN; i++)
        for (int p = 0; p < N_PU; p++)
          wmem[g*N_IN+i][p*DW +: DW] = DW'(wgt[g*N_PU+p][i]);
  endtask

  // Per-cycle monitor: address stream, output stream, stall stability, done timing.
  logic prevValid, prevStall, prevWrd, prev2Wrd, expectDone;
  logic [DW-1:0] prevData;
  logic [OW-1:0] prevIdx;
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 0; prevStall = 0; prevWrd = 0; prev2Wrd = 0; expectDone = 0;
    end else begin
      if (w_rd) begin
        if (expAddr.size() == 0) reportFail("w_addr_extra", int'(w_addr));
        else checkOutput("w_addr", int'(w_addr), expAddr.pop_front());
      end
      if (done || expectDone) checkOutput("done_timing", int'(done), int'(expectDone));
      if (done) begin
        checkOutput("argmax_at_done", int'(argmax_class), expArgmax);
        doneCount++;
      end
      expectDone = 0;
      if (out_valid) begin
        if (prevStall) begin
          checkOutput("stall_data_stable", int'(out_data), int'(prevData));
          checkOutput("stall_index_stable", int'(out_index), int'(prevIdx));
        end
        if (!prevValid) checkOutput("first_valid_latency", int'({prev2Wrd, prevWrd}), 2);
        if (out_ready) begin
          if (expData.size() == 0) reportFail("out_extra", int'(out_index));
          else begin
            int ed, ei;
            ed = expData.pop_front();
            ei = expIdx.pop_front();
            checkOutput("out_data", int'($signed(out_data)), ed);
            checkOutput("out_index", int'(out_index), ei);
            checkOutput("out_last", int'(out_last), int'(ei == N_OUT-1));
          end
          if (out_index < N_OUT) rxData[out_index] = int'($signed(out_data));
          rxCount++;
          if (out_last) expectDone = 1;
        end else begin
          stallCount++;
        end
      end
      prevStall = out_valid && !out_ready;
      prevValid = out_valid;
      prevData  = out_data;
      prevIdx   = out_index;
      prev2Wrd  = prevWrd;
      prevWrd   = w_rd;
    end
  end

  // Consumer: optionally withholds out_ready for 5 cycles at the first out_valid.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stallArm && out_valid) begin
        stallArm  = 0;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    end
  end

  task automatic sendWord(input int val);
    bit accepted;
    accepted = 0;
    in_valid = 1'b1;
    in_data  = DW'(val);
    for (int c = 0; c < 20 && !accepted; c++) begin
      accepted = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!accepted) reportFail("in_handshake_timeout", val);
  endtask

  task automatic applyStimulus(input logic relu, input bit bubbles, input bit stall);
    int cyc;
    buildModel(relu);
    rxCount = 0; doneCount = 0; stallCount = 0;
    for (int n = 0; n < N_OUT; n++) rxData[n] = -999;
    stallArm = stall;
    in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    checkOutput("idle_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    relu_en = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; relu_en = ~relu;
    checkOutput("start_to_in_ready", int'(in_ready), 1);
    for (int i = 0; i < N_IN; i++) begin
      sendWord(inVec[i]);
      if (bubbles) begin @(posedge clk); #1; end
    end
    cyc = 0;
    while (doneCount == 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (doneCount == 0) reportFail("done_timeout", cyc);
    repeat (3) @(posedge clk); #1;
    checkOutput("done_pulses", doneCount, 1);
    checkOutput("outputs_delivered", rxCount, N_OUT);
    checkOutput("addr_all_issued", expAddr.size(), 0);
    checkOutput("idle_after_done", int'(in_ready), 0);
    if (stall) checkOutput("stall_cycles", stallCount, 5);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
    checkOutput({tag, "_w_rd"}, int'(w_rd), 0);
    checkOutput({tag, "_w_addr"}, int'(w_addr), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_data"}, int'(out_data), 0);
    checkOutput({tag, "_out_index"}, int'(out_index), 0);
    checkOutput({tag, "_out_last"}, int'(out_last), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_argmax"}, int'(argmax_class), 0);
  endtask

  task automatic setInputs(input int a, input int b, input int c, input int d);
    inVec[0] = a; inVec[1] = b; inVec[2] = c; inVec[3] = d;
  endtask

  task automatic setUniformWeights(input int w);
    for (int n = 0; n < G*N_PU; n++)
      for (int i = 0; i < N_IN; i++) wgt[n][i] = w;
  endtask

  task automatic checkRun(input string tag, input int o0, input int o1, input int o2, input int am);
    checkOutput({tag, "_out0"}, rxData[0], o0);
    checkOutput({tag, "_out1"}, rxData[1], o1);
    checkOutput({tag, "_out2"}, rxData[2], o2);
    checkOutput({tag, "_argmax"}, int'(argmax_class), am);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; in_data = '0; stallArm = 0;
    repeat (3) @(posedge clk); #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    setInputs(1, 2, 3, 4);
    setUniformWeights(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkRun("t1", 10, 10, 10, 0);

    for (int n = 0; n < G*N_PU; n++)
      for (int i = 0; i < N_IN; i++) wgt[n][i] = (n % 2 == 1) ? -1 : 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkRun("neg_relu", 10, 0, 10, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkRun("neg_lin", 10, -10, 10, 0);

    setInputs(127, 127, 127, 127);
    setUniformWeights(127);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkRun("sat_pos", 127, 127, 127, 0);
    setUniformWeights(-128);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkRun("sat_neg", -128, -128, -128, 0);

    setInputs(1, 2, 3, 4);
    setUniformWeights(1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkRun("stall", 10, 10, 10, 0);

    // Unemitted lane 3 gets large weights: it must not leak into outputs or argmax.
    wgt[0] = '{1, 1, 0, 0};
    wgt[1] = '{0, 0, 3, 0};
    wgt[2] = '{1, 0, 0, 2};
    wgt[3] = '{5, 5, 5, 5};
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkRun("argmax", 3, 9, 9, 1);

    setUniformWeights(1);
    buildModel(1'b0);
    doneCount = 0;
    relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N_IN; i++) sendWord(inVec[i]);
    repeat (2) @(posedge clk); #1;
    checkOutput("rst_in_compute_w_rd", int'(w_rd), 1);
    rst = 1'b1;
    #1;
    checkResetState("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrun_no_done", doneCount, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkRun("rerun", 10, 10, 10, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
